parking_slot_arbiter: RTL and testbench

//  Shares NUM_SLOTS parking bays between NUM_LANES entry lanes. Each lane's gate/password controller

---
 rtl/parking_slot_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_parking_slot_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_arbiter.sv
// rtl/parking_slot_arbiter.sv - round-robin lane arbiter reserving the lowest free parking bay
// Optional feature macro: RESERVED_SLOT_EN (bay NUM_SLOTS-1 kept for lane 0)
module parking_slot_arbiter #(
    parameter int NUM_LANES   = 4,
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_W      = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req,
    input  logic [NUM_LANES-1:0] ack,
    input  logic                 rel_valid,
    input  logic [SLOT_W-1:0]    rel_slot,
    output logic [NUM_LANES-1:0] grant,
    output logic [SLOT_W-1:0]    grant_slot,
    output logic [SLOT_W:0]      occupancy,
    output logic                 full,
    output logic                 rel_err,
    output logic                 timeout
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

`ifdef RESERVED_SLOT_EN
    localparam logic [NUM_SLOTS-1:0] POOL_MASK = {1'b0, {(NUM_SLOTS-1){1'b1}}};
`else
    localparam logic [NUM_SLOTS-1:0] POOL_MASK = {NUM_SLOTS{1'b1}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_GNT
    } state_t;

    state_t               state, state_n;
    logic [NUM_SLOTS-1:0] bitmap, bitmap_n;
    logic [LANE_W-1:0]    rr_ptr, rr_ptr_n;
    logic [LANE_W-1:0]    gnt_lane, gnt_lane_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [NUM_LANES-1:0] grant_n;
    logic [SLOT_W-1:0]    grant_slot_n;
    logic [SLOT_W:0]      occupancy_n;
    logic                 full_n, rel_err_n, timeout_n;

    logic [NUM_LANES-1:0] eligible;
    logic [NUM_SLOTS-1:0] lane_mask;
    logic [NUM_SLOTS-1:0] free_bays;
    logic [LANE_W-1:0]    pick_lane;
    logic [SLOT_W-1:0]    pick_slot;
    logic                 pick_found, slot_found;
    logic                 idle_go;
    logic                 rel_hit, rel_pending, rel_ok;
    logic [LANE_W-1:0]    rr_after;

    // Arbitration and bay choice are evaluated on the pre-release bitmap.
    always_comb begin
`ifdef RESERVED_SLOT_EN
        eligible = full ? (req & NUM_LANES'(1)) : req;
        idle_go  = ((|req) && !full) || (req[0] && !bitmap[NUM_SLOTS-1]);
`else
        eligible = req;
        idle_go  = (|req) && !full;
`endif
        pick_found = 1'b0;
        pick_lane  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!pick_found && eligible[(int'(rr_ptr) + k) % NUM_LANES]) begin
                pick_found = 1'b1;
                pick_lane  = LANE_W'((int'(rr_ptr) + k) % NUM_LANES);
            end
        end
        lane_mask  = (pick_lane == '0) ? {NUM_SLOTS{1'b1}} : POOL_MASK;
        free_bays  = ~bitmap & lane_mask;
        slot_found = 1'b0;
        pick_slot  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_found && free_bays[i]) begin
                slot_found = 1'b1;
                pick_slot  = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        rel_hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rel_slot == SLOT_W'(i) && bitmap[i]) begin
                rel_hit = 1'b1;
            end
        end
        rel_pending = (state == S_GNT) && (rel_slot == grant_slot);
        rel_ok      = rel_valid && rel_hit && !rel_pending;
        rr_after    = LANE_W'((int'(gnt_lane) + 1) % NUM_LANES);
    end

    always_comb begin
        state_n      = state;
        bitmap_n     = bitmap;
        rr_ptr_n     = rr_ptr;
        gnt_lane_n   = gnt_lane;
        cnt_n        = cnt;
        grant_n      = grant;
        grant_slot_n = grant_slot;
        timeout_n    = 1'b0;
        rel_err_n    = rel_valid && !rel_ok;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rel_ok && rel_slot == SLOT_W'(i)) begin
                bitmap_n[i] = 1'b0;
            end
        end

        case (state)
            S_IDLE: begin
                if (idle_go) begin
                    state_n = S_ARB;
                end
            end
            S_ARB: begin
                if (pick_found && slot_found) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (pick_slot == SLOT_W'(i)) begin
                            bitmap_n[i] = 1'b1;
                        end
                    end
                    grant_n      = NUM_LANES'(1) << pick_lane;
                    grant_slot_n = pick_slot;
                    gnt_lane_n   = pick_lane;
                    cnt_n        = '0;
                    state_n      = S_GNT;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GNT: begin
                cnt_n = cnt + 1'b1;
                if (ack[gnt_lane]) begin
                    grant_n  = '0;
                    rr_ptr_n = rr_after;
                    state_n  = S_IDLE;
                end else if (!req[gnt_lane] || cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (grant_slot == SLOT_W'(i)) begin
                            bitmap_n[i] = 1'b0;
                        end
                    end
                    timeout_n = 1'b1;
                    grant_n   = '0;
                    rr_ptr_n  = rr_after;
                    state_n   = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
            end
        endcase

        // Status is derived from the next bitmap so it stays aligned with the registered bitmap.
        occupancy_n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occupancy_n = occupancy_n + (SLOT_W + 1)'(bitmap_n[i]);
        end
        full_n = &(bitmap_n | ~POOL_MASK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            bitmap     <= '0;
            rr_ptr     <= '0;
            gnt_lane   <= '0;
            cnt        <= '0;
            grant      <= '0;
            grant_slot <= '0;
            occupancy  <= '0;
            full       <= 1'b0;
            rel_err    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            bitmap     <= bitmap_n;
            rr_ptr     <= rr_ptr_n;
            gnt_lane   <= gnt_lane_n;
            cnt        <= cnt_n;
            grant      <= grant_n;
            grant_slot <= grant_slot_n;
            occupancy  <= occupancy_n;
            full       <= full_n;
            rel_err    <= rel_err_n;
            timeout    <= timeout_n;
        end
    end

endmodule

// File: tb/tb_parking_slot_arbiter.sv
// tb/tb_parking_slot_arbiter.sv - directed self-checking bench for parking_slot_arbiter
module tb_parking_slot_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, ack;
    logic       rel_valid;
    logic [2:0] rel_slot;
    logic [3:0] grant;
    logic [2:0] grant_slot;
    logic [3:0] occupancy;
    logic       full, rel_err, timeout;

    int errors = 0;
    int checks = 0;

    parking_slot_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack),
        .rel_valid(rel_valid), .rel_slot(rel_slot),
        .grant(grant), .grant_slot(grant_slot), .occupancy(occupancy),
        .full(full), .rel_err(rel_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] ack;
        logic [3:0] g;
        logic [2:0] s;
        logic [3:0] occ;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, logic [3:0] rq, logic [3:0] ak, logic [3:0] g,
                                logic [2:0] s, logic [3:0] occ);
        vec_t v;
        v.rst = r; v.req = rq; v.ack = ak; v.g = g; v.s = s; v.occ = occ;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic release_bay(input logic [2:0] s);
        rel_valid = 1'b1;
        rel_slot  = s;
        step();
        rel_valid = 1'b0;
    endtask

    task automatic get_grant(input logic [3:0] r, input logic [3:0] eg, input logic [2:0] es,
                             input bit do_ack);
        int n;
        n   = 0;
        req = r;
        do begin
            step();
            n++;
        end while (grant == 4'b0 && n < 8);
        chk("grant_lane", grant, eg);
        chk("grant_slot", grant_slot, es);
        if (do_ack) begin
            ack = eg;
            step();
            ack = 4'b0;
            req = 4'b0;
            chk("grant_drop_on_ack", grant, 4'b0);
        end
    endtask

    task automatic hold_no_grant(input logic [3:0] r);
        bit bad;
        bad = 1'b0;
        req = r;
        repeat (6) begin
            step();
            if (grant != 4'b0) bad = 1'b1;
        end
        chk("no_grant_while_full", bad, 1'b0);
    endtask

    initial begin
        reset = 1'b1; req = '0; ack = '0; rel_valid = 1'b0; rel_slot = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_grant", grant, 4'b0);
        chk("reset_slot", grant_slot, 3'd0);
        chk("reset_occ", occupancy, 4'd0);
        chk("reset_full", full, 1'b0);
        chk("reset_relerr", rel_err, 1'b0);
        chk("reset_timeout", timeout, 1'b0);

`ifdef RESERVED_SLOT_EN
        for (int i = 0; i < 7; i++) get_grant(4'b0010, 4'b0010, 3'(i), 1'b1);
        chk("rsv_occ7", occupancy, 4'd7);
        chk("rsv_full", full, 1'b1);
        hold_no_grant(4'b0010);
        req = 4'b0;
        get_grant(4'b0001, 4'b0001, 3'd7, 1'b0);
        chk("rsv_occ8", occupancy, 4'd8);
        #2;
        reset = 1'b1;
        #1;
        chk("rsv_async_grant", grant, 4'b0);
        chk("rsv_async_occ", occupancy, 4'd0);
        step();
        reset = 1'b0;
`else
        // Single lane: two-cycle latency then ack commit; then fresh round-robin over 4 lanes.
        add(0, 4'b0001, 4'b0000, 4'b0000, 3'd0, 4'd0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 3'd0, 4'd1);
        add(0, 4'b0001, 4'b0001, 4'b0000, 3'd0, 4'd1);
        for (int l = 0; l < 5; l++) begin
            add(l == 0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 4'(l));
            add(0, 4'b1111, 4'b0000, 4'(1 << (l % 4)), 3'(l), 4'(l + 1));
            add(0, 4'b1111, 4'(1 << (l % 4)), 4'b0000, 3'd0, 4'(l + 1));
        end
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            req = tbl[i].req;
            ack = tbl[i].ack;
            step();
            chk($sformatf("vec%0d_grant", i), grant, tbl[i].g);
            if (tbl[i].g != 4'b0) chk($sformatf("vec%0d_slot", i), grant_slot, tbl[i].s);
            chk($sformatf("vec%0d_occ", i), occupancy, tbl[i].occ);
            chk($sformatf("vec%0d_flags", i), {full, rel_err, timeout}, 3'b000);
        end
        req = 4'b0;
        ack = 4'b0;

        // Fill the lot, confirm full blocks grants, then free bay 5 and reuse it.
        get_grant(4'b0010, 4'b0010, 3'd5, 1'b1);
        get_grant(4'b0100, 4'b0100, 3'd6, 1'b1);
        get_grant(4'b1000, 4'b1000, 3'd7, 1'b1);
        chk("full_occ8", occupancy, 4'd8);
        chk("full_set", full, 1'b1);
        hold_no_grant(4'b0010);
        release_bay(3'd5);
        chk("rel5_full", full, 1'b0);
        chk("rel5_occ", occupancy, 4'd7);
        chk("rel5_err", rel_err, 1'b0);
        get_grant(4'b0010, 4'b0010, 3'd5, 1'b1);
        chk("refull", full, 1'b1);

        // Grant without ack: abandoned after exactly 15 cycles, bay then reused.
        release_bay(3'd2);
        chk("rel2_occ", occupancy, 4'd7);
        get_grant(4'b0001, 4'b0001, 3'd2, 1'b0);
        chk("tmo_occ_during", occupancy, 4'd8);
        begin
            bit early;
            early = 1'b0;
            for (int k = 1; k < 15; k++) begin
                step();
                if (timeout || grant != 4'b0001) early = 1'b1;
            end
            chk("tmo_not_early", early, 1'b0);
        end
        step();
        chk("tmo_pulse", timeout, 1'b1);
        chk("tmo_grant", grant, 4'b0);
        chk("tmo_occ", occupancy, 4'd7);
        step();
        chk("tmo_one_cycle", timeout, 1'b0);
        get_grant(4'b0001, 4'b0001, 3'd2, 1'b1);
        chk("tmo_reuse_occ", occupancy, 4'd8);

        // Illegal releases: free bay and pending bay; req drop abandons the grant.
        release_bay(3'd3);
        chk("rel3_ok_err", rel_err, 1'b0);
        chk("rel3_ok_occ", occupancy, 4'd7);
        release_bay(3'd3);
        chk("rel_free_err", rel_err, 1'b1);
        chk("rel_free_occ", occupancy, 4'd7);
        step();
        chk("rel_err_pulse", rel_err, 1'b0);
        get_grant(4'b0100, 4'b0100, 3'd3, 1'b0);
        release_bay(3'd3);
        chk("rel_pend_err", rel_err, 1'b1);
        chk("rel_pend_occ", occupancy, 4'd8);
        chk("rel_pend_grant", grant, 4'b0100);
        req = 4'b0;
        step();
        chk("drop_timeout", timeout, 1'b1);
        chk("drop_grant", grant, 4'b0);
        chk("drop_occ", occupancy, 4'd7);

        // Asynchronous reset in GNT clears outputs without a clock edge.
        get_grant(4'b0100, 4'b0100, 3'd3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_grant", grant, 4'b0);
        chk("async_occ", occupancy, 4'd0);
        chk("async_full", full, 1'b0);
        step();
        reset = 1'b0;
        req = 4'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
